mseq_bit_source: RTL and testbench
==================================

Name: mseq_bit_source

Overview:
- Paced pseudo-random bit source for the BPSK transmit chain.
- An interval timer produces a one-cycle enable strobe every INTERVAL clocks while start is high.
- Each strobe advances a 7-bit maximal-length LFSR (m-sequence, period 127).
- The resulting bit is presented with a one-cycle valid qualifier for the downstream modulator.

Parameters:
- INTERVAL, 50: strobe period in clk cycles; legal range 2..65535.
- SEED, 7'h01: LFSR load value on reset; must be non-zero.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; 1 = run interval timer, 0 = stop and clear timer.
- en  output  1  registered strobe; one cycle high every INTERVAL cycles while running.
- data_out  output  1  current m-sequence bit; valid only when data_vld=1.
- data_vld  output  1  one-cycle qualifier for data_out.

Behaviour:
- Reset values (asynchronous): counter=0, en=0, lfsr=SEED, data_out=0, data_vld=0.
- Interval timer:
  - counter width is ceil(log2(INTERVAL)).
  - While start=1: counter increments 0..INTERVAL-1 and wraps to 0.
  - en is registered: en <= (start && counter==INTERVAL-1).
  - While start=0: counter <= 0 and en <= 0.
  - After reset release with start=1: first en is high in the cycle following the INTERVAL-th rising edge. Subsequent en pulses are exactly INTERVAL cycles apart and never wider than one cycle.
- m-sequence:
  - State s[6:0], polynomial x^7+x^6+1.
  - Feedback fb = s[6] ^ s[5].
  - On a clock edge with en=1: data_out <= s[6], s <= {s[5:0], fb}, data_vld <= 1.
  - Otherwise data_vld <= 0; data_out and s hold.
- Latency: data_vld rises one cycle after en and lasts one cycle.
- Lock-up guard: if s==0 at an en cycle, reload SEED instead of shifting. This is unreachable in normal operation.
- Sequence from SEED=7'h01, first 8 bits: 0,0,0,0,0,0,1,0.
  - Period is 127 valid bits: 64 ones and 63 zeros, no run of 7 zeros.
  - The sequence repeats identically from bit 128.
- start toggling: LFSR state is preserved across stop/restart. Only the timer restarts, so the first en after restart comes INTERVAL cycles after start rises.
- Reset mid-operation: all state returns to reset values immediately. The sequence restarts from SEED.

Decomposition:
- Shared package mseq_pkg:
  - LFSR_W=7
  - tap mask 7'b1100000
  - default SEED
- One sub-module: interval_pulse (counter plus registered en, parameter INTERVAL, ports clk/rst/start/en).
- The LFSR and output registers live in the top level.

Test Plan:
- Reset then start=1, INTERVAL=50: en first high 50 cycles after rst release. Then every 50 cycles, width 1. data_vld high exactly 1 cycle after each en.
- Sequence check: first 8 data_out at data_vld = 0,0,0,0,0,0,1,0. Bits 1..127 equal bits 128..254. Count of ones per 127 = 64.
- start=0 for 200 cycles mid-run: no en and no data_vld. After start=1 again, next en is 50 cycles later and the bit stream continues with no repeat or skip.
- Assert rst for 3 cycles mid-sequence: outputs clear asynchronously. The next valid bits restart at 0,0,0,0,0,0,1,0.
- INTERVAL=2 build: en toggles every other cycle. data_vld is never high for two consecutive cycles. Full 127-bit period is produced in 254 cycles.

Source files
------------

// File: rtl/mseq_pkg.sv
// Shared constants for the paced m-sequence bit source.
// The feedback helper keeps the tap definition in one place.
package mseq_pkg;

  localparam int unsigned LFSR_W = 7;

  // x^7 + x^6 + 1: feedback taps on s[6] and s[5]
  localparam logic [LFSR_W-1:0] TAP_MASK = 7'b1100000;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h01;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & TAP_MASK);
  endfunction

endpackage

// File: rtl/interval_pulse.sv
// Interval timer: one-cycle registered strobe every INTERVAL clocks while start is high.
// Dropping start clears the count so a restart always waits a full interval.
module interval_pulse #(
  parameter int unsigned INTERVAL = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic en
);

  localparam int unsigned CntW = $clog2(INTERVAL);
  localparam logic [CntW-1:0] CntLast = CntW'(INTERVAL - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_en;
  logic            w_last;

  assign w_last = (r_cnt == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (start) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      r_en  <= w_last;
    end else begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end
  end

  assign en = r_en;

endmodule

// File: rtl/mseq_bit_source.sv
// Paced pseudo-random bit source: each timer strobe advances a 7-bit m-sequence LFSR
// and presents the outgoing bit with a one-cycle valid qualifier.
module mseq_bit_source
  import mseq_pkg::*;
#(
  parameter int unsigned       INTERVAL = 50,
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic en,
  output logic data_out,
  output logic data_vld
);

  logic              w_en;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic              r_data_out;
  logic              r_data_vld;

  interval_pulse #(
    .INTERVAL (INTERVAL)
  ) u_interval_pulse (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .en    (w_en)
  );

  // An all-zero state would stick forever; reload the seed rather than shift it.
  always_comb begin
    w_lfsr_next = SEED;
    if (r_lfsr != '0) begin
      w_lfsr_next = {r_lfsr[LFSR_W-2:0], lfsr_fb(r_lfsr)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr     <= SEED;
      r_data_out <= 1'b0;
      r_data_vld <= 1'b0;
    end else if (w_en) begin
      r_lfsr     <= w_lfsr_next;
      r_data_out <= r_lfsr[LFSR_W-1];
      r_data_vld <= 1'b1;
    end else begin
      r_data_vld <= 1'b0;
    end
  end

  assign en       = w_en;
  assign data_out = r_data_out;
  assign data_vld = r_data_vld;

endmodule

// File: tb/tb_mseq_bit_source.sv
// Bench for mseq_bit_source: INTERVAL=50 and INTERVAL=2 instances share clock, reset and start;
// a recurrence-based sequence and a run-length timer model predict every output each cycle.
module tb_mseq_bit_source;

  localparam int unsigned IV0 = 50;
  localparam int unsigned IV1 = 2;
  localparam int          SEQ_N = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic en0, dout0, vld0;
  logic en1, dout1, vld1;

  mseq_bit_source #(.INTERVAL(IV0), .SEED(7'h01)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en0),
    .data_out (dout0),
    .data_vld (vld0)
  );

  mseq_bit_source #(.INTERVAL(IV1), .SEED(7'h01)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en1),
    .data_out (dout1),
    .data_vld (vld1)
  );

  always #5 clk = ~clk;

  bit seq[SEQ_N];
  int errors = 0;
  int checks = 0;

  int run_m[2];
  bit en_m[2];
  bit vld_m[2];
  bit dout_m[2];
  int idx_m[2];

  int cyc;
  int first_en_cyc;
  bit obs0[$];
  int en1_cnt;
  int vld1_pairs;
  bit prev_vld1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      run_m[d]  = 0;
      en_m[d]   = 1'b0;
      vld_m[d]  = 1'b0;
      dout_m[d] = 1'b0;
      idx_m[d]  = 0;
    end
  endfunction

  // Timer: en follows every INTERVAL-th consecutive edge with start high.
  function automatic void model_edge();
    int iv;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      iv = (d == 0) ? IV0 : IV1;
      vld_m[d] = en_m[d];
      if (en_m[d]) begin
        dout_m[d] = seq[idx_m[d]];
        idx_m[d]++;
      end
      if (start) begin
        run_m[d]++;
        en_m[d] = (run_m[d] % iv) == 0;
      end else begin
        run_m[d] = 0;
        en_m[d]  = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_eq("en0",   en0,   en_m[0]);
    check_eq("vld0",  vld0,  vld_m[0]);
    check_eq("dout0", dout0, dout_m[0]);
    check_eq("en1",   en1,   en_m[1]);
    check_eq("vld1",  vld1,  vld_m[1]);
    check_eq("dout1", dout1, dout_m[1]);
    if (vld0) obs0.push_back(dout0);
    if (en0 && first_en_cyc < 0) first_en_cyc = cyc;
    if (en1) en1_cnt++;
    if (vld1 && prev_vld1) vld1_pairs++;
    prev_vld1 = vld1;
  endtask

  task automatic check_first8(input string tag);
    logic [7:0] pat;
    logic [7:0] got;
    pat = 8'b0000_0010;
    got = '1;
    if (obs0.size() >= 8) begin
      for (int i = 0; i < 8; i++) got[7-i] = obs0[i];
    end
    check_eq(tag, got, pat);
  endtask

  initial begin
    logic [6:0] sd;
    int ones;
    sd = 7'h01;
    // Output bit n is a[n]; new bit a[n+7] = a[n] ^ a[n+1] from x^7+x^6+1.
    for (int i = 0; i < 7; i++) seq[i] = sd[6-i];
    for (int n = 0; n + 7 < SEQ_N; n++) seq[n+7] = seq[n] ^ seq[n+1];

    cyc = 0;
    first_en_cyc = -1;
    prev_vld1 = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    check_eq("rst_en0",   en0,   0);
    check_eq("rst_vld0",  vld0,  0);
    check_eq("rst_dout0", dout0, 0);
    check_eq("rst_vld1",  vld1,  0);
    tick();
    tick();
    rst = 1'b0;
    start = 1'b1;
    cyc = 0;

    // Phase 1: free run covering a full period on the slow instance.
    repeat (IV0 * 128 + 10) tick();
    check_eq("first_en_latency", first_en_cyc, IV0);
    check_first8("first8_after_reset");
    ones = 0;
    if (obs0.size() >= 127) begin
      for (int i = 0; i < 127; i++) ones += obs0[i];
    end
    check_eq("ones_per_period", ones, 64);

    // Phase 2: long stop, then restart.
    start = 1'b0;
    repeat (200 + $urandom_range(0, 30)) tick();
    start = 1'b1;
    repeat (3000) tick();

    // Phase 3: random start toggling.
    repeat (20) begin
      start = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 120)) tick();
    end

    // Phase 4: asynchronous reset mid-run.
    start = 1'b1;
    repeat ($urandom_range(500, 1500)) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("async_en0",   en0,   0);
    check_eq("async_vld0",  vld0,  0);
    check_eq("async_dout0", dout0, 0);
    check_eq("async_en1",   en1,   0);
    check_eq("async_vld1",  vld1,  0);
    check_eq("async_dout1", dout1, 0);
    repeat (3) tick();
    rst = 1'b0;
    obs0.delete();
    en1_cnt = 0;
    vld1_pairs = 0;
    repeat (254) tick();
    check_eq("iv2_en_per_254", en1_cnt, 127);
    repeat (IV0 * 9 + 20 - 254) tick();
    check_first8("first8_after_midrun_reset");
    check_eq("iv2_no_back_to_back_vld", vld1_pairs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
